// File: rtl/pe_mult_pkg.sv
// Shared definitions for the pe_mult_pipe multiplier: pipeline depth, stage-0 sideband, width limit.
package pe_mult_pkg;

  localparam int MAX_WIDTH = 32;

  typedef struct packed {
    logic vld;
    logic sgn;
  } sb_t;

  // One operand register stage plus one register per adder-tree level.
  function automatic int depth(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/pe_pipe_reg.sv
// Generic pipeline register: synchronous active-high clear to 0, load when en is high.
module pe_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pe_mult_pipe.sv
// Fully pipelined WIDTH x WIDTH signed/unsigned multiplier with valid/ready backpressure.
// Define PE_MULT_TAG_EN to carry a TAG_W-bit sideband tag alongside each product.
module pe_mult_pipe
  import pe_mult_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef PE_MULT_TAG_EN
  ,
  parameter int TAG_W = 4
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic               busy
`ifdef PE_MULT_TAG_EN
  ,
  input  logic [TAG_W-1:0]   in_tag,
  output logic [TAG_W-1:0]   out_tag
`endif
);

  localparam int D     = depth(WIDTH);
  localparam int LVLS  = D - 1;
  localparam int PW    = 2 * WIDTH;
  localparam int NODES = 2 * WIDTH - 1;

  if (WIDTH < 4 || WIDTH > MAX_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pe_mult_pipe: WIDTH must be a power of two in 4..%0d", MAX_WIDTH);
  end

  // Partial product of one multiplier bit; the sign-bit row is negated in signed mode.
  function automatic logic signed [PW-1:0] part_prod(input logic signed [PW-1:0] a_ext,
                                                     input logic b_bit,
                                                     input logic neg);
    logic signed [PW-1:0] p;
    p = b_bit ? a_ext : '0;
    return neg ? -p : p;
  endfunction

  logic                 adv;
  logic [LVLS:0]        vld_p;
  sb_t                  sb_d;
  sb_t                  sb_p0;
  logic [WIDTH-1:0]     a_p0;
  logic [WIDTH-1:0]     b_p0;
  logic signed [PW-1:0] a_ext_p0;
  // Tree nodes: [0, WIDTH) are stage-0 partial products, then each registered level in turn.
  logic [PW-1:0]        node [NODES];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign sb_d     = '{vld: in_valid && adv, sgn: in_signed};

  // Stage 0: operand capture
  pe_pipe_reg #(.WIDTH(WIDTH)) u_a_p0 (
    .clk(clk), .rst(rst), .en(adv), .d(in_a), .q(a_p0)
  );
  pe_pipe_reg #(.WIDTH(WIDTH)) u_b_p0 (
    .clk(clk), .rst(rst), .en(adv), .d(in_b), .q(b_p0)
  );
  pe_pipe_reg #(.WIDTH($bits(sb_t))) u_sb_p0 (
    .clk(clk), .rst(rst), .en(adv), .d(sb_d), .q(sb_p0)
  );

  assign vld_p[0]  = sb_p0.vld;
  assign a_ext_p0  = {{WIDTH{sb_p0.sgn & a_p0[WIDTH-1]}}, a_p0};

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    assign node[i] = part_prod(a_ext_p0, b_p0[i], sb_p0.sgn && (i == WIDTH - 1)) << i;
  end

`ifdef PE_MULT_TAG_EN
  logic [TAG_W-1:0] tag_p [D];

  pe_pipe_reg #(.WIDTH(TAG_W)) u_tag_p0 (
    .clk(clk), .rst(rst), .en(adv), .d(in_tag), .q(tag_p[0])
  );
`endif

  // Stages 1..LVLS: one pairwise adder level per stage; the last one is the output register
  for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
    localparam int N    = WIDTH >> l;
    localparam int OFF  = 2 * WIDTH - 2 * N;
    localparam int POFF = 2 * WIDTH - 4 * N;

    for (genvar j = 0; j < N; j++) begin : g_node
      logic [PW-1:0] sum;
      assign sum = node[POFF + 2 * j] + node[POFF + 2 * j + 1];
      pe_pipe_reg #(.WIDTH(PW)) u_sum (
        .clk(clk), .rst(rst), .en(adv), .d(sum), .q(node[OFF + j])
      );
    end

    pe_pipe_reg #(.WIDTH(1)) u_vld (
      .clk(clk), .rst(rst), .en(adv), .d(vld_p[l-1]), .q(vld_p[l])
    );

`ifdef PE_MULT_TAG_EN
    pe_pipe_reg #(.WIDTH(TAG_W)) u_tag (
      .clk(clk), .rst(rst), .en(adv), .d(tag_p[l-1]), .q(tag_p[l])
    );
`endif
  end

  assign out_valid = vld_p[LVLS];
  assign out_data  = node[NODES-1];
  assign busy      = |vld_p;

`ifdef PE_MULT_TAG_EN
  assign out_tag = tag_p[LVLS];
`endif

endmodule

// File: tb/tb_pe_mult_pipe.sv
// Self-checking bench for pe_mult_pipe: scoreboard model plus directed, random, stall and reset cases.
module tb_pe_mult_pipe;

`ifdef PE_MULT_TAG_EN
  localparam int W = 16;
`else
  localparam int W = 8;
`endif
  localparam int D  = $clog2(W) + 1;
  localparam int PW = 2 * W;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a      = '0;
  logic [W-1:0]  in_b      = '0;
  logic          in_signed = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] out_data;
  logic          busy;
  logic [3:0]    drv_tag   = '0;
`ifdef PE_MULT_TAG_EN
  logic [3:0]    out_tag;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [PW-1:0] data;
    logic [3:0]    tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;

  always #5 clk = ~clk;

  pe_mult_pipe #(
    .WIDTH(W)
`ifdef PE_MULT_TAG_EN
    ,
    .TAG_W(4)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_signed(in_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy)
`ifdef PE_MULT_TAG_EN
    ,
    .in_tag(drv_tag),
    .out_tag(out_tag)
`endif
  );

  // Reference product: interpret operands as integers and multiply, keep 2*W bits.
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sg);
    longint sa;
    longint sb;
    sa = longint'(a);
    sb = longint'(b);
    if (sg && a[W-1]) sa = sa - (longint'(1) << W);
    if (sg && b[W-1]) sb = sb - (longint'(1) << W);
    return PW'(sa * sb);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sg, input logic [3:0] tg);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_signed = sg;
    drv_tag   = tg;
  endtask

  task automatic drive_rand();
    drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 4'($urandom));
  endtask

  task automatic drive_idle();
    drive(1'b0, '0, '0, 1'b0, 4'h0);
    in_a = 'x;
    in_b = 'x;
  endtask

  // Drain with out_ready held high; reports how many result cycles were seen.
  task automatic drain(input string nm, output int n_out);
    int n;
    n     = 0;
    n_out = 0;
    while (busy && n < 200) begin
      if (out_valid) n_out++;
      tick();
      n++;
    end
    check({nm, "_drain_timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sg, input logic [3:0] tg, input logic [PW-1:0] lit);
    int lat;
    drive(1'b1, a, b, sg, tg);
    check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    drive_idle();
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'(D - 1));
    check({nm, "_data"}, 64'(out_data), 64'(lit));
`ifdef PE_MULT_TAG_EN
    check({nm, "_tag"}, 64'(out_tag), 64'(tg));
`endif
    tick();
  endtask

  // Scoreboard: every accepted operand pair must come out once, in order, with its product.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      check("busy", 64'(busy), 64'(exp_q.size() != 0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          e_mon = exp_q.pop_front();
          check("data", 64'(out_data), 64'(e_mon.data));
`ifdef PE_MULT_TAG_EN
          check("tag", 64'(out_tag), 64'(e_mon.tag));
`endif
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{data: ref_mul(in_a, in_b, in_signed), tag: drv_tag});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0]  mn1, mp, mx;
    logic [PW-1:0] lit_ff, lit_mm, lit_sm, lit_um, held;
    logic [PW-1:0] got [3];
    int            ngot, ones, first, last, n_out, n;

    mn1 = '1;
    mp  = {1'b0, {(W-1){1'b1}}};
    mx  = {1'b1, {(W-1){1'b0}}};
`ifdef PE_MULT_TAG_EN
    lit_ff = 32'hFFFE0001;
    lit_mm = 32'h40000000;
    lit_sm = 32'hFFFF8001;
    lit_um = 32'h7FFE8001;
`else
    lit_ff = 16'hFE01;
    lit_mm = 16'h4000;
    lit_sm = 16'hFF81;
    lit_um = 16'h7E81;
`endif

    check("pin_uff", 64'(ref_mul(mn1, mn1, 1'b0)), 64'(lit_ff));
    check("pin_smm", 64'(ref_mul(mx, mx, 1'b1)), 64'(lit_mm));
    check("pin_ssm", 64'(ref_mul(mn1, mp, 1'b1)), 64'(lit_sm));
    check("pin_usm", 64'(ref_mul(mn1, mp, 1'b0)), 64'(lit_um));

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef PE_MULT_TAG_EN
    check("rst_out_tag", 64'(out_tag), 64'd0);
`endif

    directed("uff", mn1, mn1, 1'b0, 4'hA, lit_ff);
    directed("smm", mx, mx, 1'b1, 4'h5, lit_mm);
    directed("ssm", mn1, mp, 1'b1, 4'h3, lit_sm);
    directed("usm", mn1, mp, 1'b0, 4'hC, lit_um);

    // Mixed signed/unsigned back to back
    drive(1'b1, mx, mx, 1'b1, 4'h1);
    tick();
    drive(1'b1, mn1, mp, 1'b1, 4'h2);
    tick();
    drive(1'b1, mn1, mp, 1'b0, 4'h3);
    tick();
    drive_idle();
    ngot = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && ngot < 3) begin
        got[ngot] = out_data;
        ngot++;
      end
      tick();
    end
    check("mix_count", 64'(ngot), 64'd3);
    check("mix_smm", 64'(got[0]), 64'(lit_mm));
    check("mix_ssm", 64'(got[1]), 64'(lit_sm));
    check("mix_usm", 64'(got[2]), 64'(lit_um));

    // 16 back-to-back random operands at full rate
    ones  = 0;
    first = -1;
    last  = -1;
    for (int i = 0; i < 16 + D + 2; i++) begin
      if (i < 16) begin
        drive_rand();
        check("rand_in_ready", 64'(in_ready), 64'd1);
      end else begin
        drive_idle();
      end
      tick();
      if (out_valid) begin
        ones++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("rand_count", 64'(ones), 64'd16);
    check("rand_first", 64'(first), 64'(D - 1));
    check("rand_contig", 64'(last - first + 1), 64'd16);

    // Backpressure with a full pipe
    out_ready = 1'b0;
    for (int i = 0; i < D; i++) begin
      drive_rand();
      tick();
    end
    drive_rand();
    held = out_data;
    check("bp_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold", 64'(out_data), 64'(held));
      tick();
    end
    drive_idle();
    out_ready = 1'b1;
    drain("bp", n_out);
    check("bp_count", 64'(n_out), 64'(D));
    check("bp_queue", 64'(exp_q.size()), 64'd0);

    // Reset with transactions in flight
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      tick();
    end
    rst = 1'b1;
    drive_idle();
    tick();
    rst = 1'b0;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
`ifdef PE_MULT_TAG_EN
    check("mid_rst_out_tag", 64'(out_tag), 64'd0);
`endif
    n = 0;
    for (int i = 0; i < D + 5; i++) begin
      tick();
      if (out_valid) n++;
    end
    check("mid_rst_stale", 64'(n), 64'd0);

    // Random traffic with random backpressure and idle gaps
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) drive_rand();
      else drive_idle();
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drive_idle();
    out_ready = 1'b1;
    drain("soak", n_out);
    check("soak_queue", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
